// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM state encoding and the canonical NOP
// (addi x0, x0, 0) used to fill the IF/ID register when nothing is live.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    ISSUE,
    WAIT,
    HOLD,
    DROP,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory port: single-outstanding request pulse with a later
// response strobe. The fetch unit is the master, the memory the slave.
interface fetch_pc_unit_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             req;
  logic [PC_W-1:0]  addr;
  logic [INS_W-1:0] rdata;
  logic             rvalid;

  modport master (output req, addr, input rdata, rvalid);
  modport slave  (input req, addr, output rdata, rvalid);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for a fetched {pc, instr} pair that arrived while the
// hazard unit was stalling IF/ID. Clear wins over load, load wins over pop.
module fetch_skid_buf #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             pop,
  input  logic             clear,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [INS_W-1:0] in_instr,
  output logic             valid,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_instr
);

  logic             valid_q, valid_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] instr_q, instr_d;

  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned, which would otherwise infer a latch.
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: the payload is not reset; it is only ever read while valid_q is set,
  // so resetting it would just add reset fan-out to a plain data register.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

  assign valid     = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues single-outstanding instruction fetches,
// fills IF/ID (with a skid entry for stalls) and honours EX redirects/halt.
module fetch_pc_unit
  import pipeline_pkg::*;
#(
  parameter int PC_W     = 9,
  parameter int INS_W    = 32,
  parameter int RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   pc_sel,
  input  logic [31:0]            br_pc,
  input  logic                   halt,
  fetch_pc_unit_if.master        imem,
  output logic [PC_W-1:0]        if_pc,
  output logic [PC_W-1:0]        id_pc,
  output logic [INS_W-1:0]       id_instr,
  output logic                   id_valid,
  output logic                   flush,
  output logic                   halted
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  id_pc_q, id_pc_d;
  logic [INS_W-1:0] id_instr_q, id_instr_d;
  logic             id_valid_q, id_valid_d;

  logic             skid_load, skid_pop, skid_clear, skid_valid;
  logic [PC_W-1:0]  skid_pc;
  logic [INS_W-1:0] skid_instr;

  logic [PC_W-1:0]  pc_inc, redirect_pc;
  logic             unused_br_bits;

  // Sequential PC wraps modulo 2^PC_W; redirect targets are forced word aligned.
  assign pc_inc         = pc_q + PC_W'(4);
  assign redirect_pc    = {br_pc[PC_W-1:2], 2'b00};
  assign unused_br_bits = ^{br_pc[31:PC_W], br_pc[1:0]};

  fetch_skid_buf #(.PC_W(PC_W), .INS_W(INS_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .pop       (skid_pop),
    .clear     (skid_clear),
    .in_pc     (pc_q),
    .in_instr  (imem.rdata),
    .valid     (skid_valid),
    .out_pc    (skid_pc),
    .out_instr (skid_instr)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    if (pc_sel && state_q != HALTED) begin
      pc_d       = redirect_pc;
      id_valid_d = 1'b0;
      skid_clear = 1'b1;
      // An in-flight fetch that has not answered yet must still be drained.
      if (halt) begin
        state_d = HALTED;
      end else if ((state_q == WAIT || state_q == DROP) && !imem.rvalid) begin
        state_d = DROP;
      end else begin
        state_d = ISSUE;
      end
    end else begin
      case (state_q)
        ISSUE: begin
          if (!stall) state_d = WAIT;
        end
        WAIT: begin
          if (imem.rvalid) begin
            pc_d = pc_inc;
            if (stall) begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end else begin
              id_instr_d = imem.rdata;
              id_pc_d    = pc_q;
              id_valid_d = 1'b1;
              state_d    = ISSUE;
            end
          end else if (!stall) begin
            id_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall && skid_valid) begin
            id_instr_d = skid_instr;
            id_pc_d    = skid_pc;
            id_valid_d = 1'b1;
            skid_pop   = 1'b1;
            state_d    = ISSUE;
          end
        end
        DROP: begin
          id_valid_d = 1'b0;
          if (imem.rvalid) state_d = ISSUE;
        end
        HALTED: begin
          id_valid_d = 1'b0;
        end
        default: begin
          state_d = ISSUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ISSUE;
      pc_q       <= PC_W'(RESET_PC);
      id_pc_q    <= '0;
      id_instr_q <= INS_W'(NOP_INSTR);
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign halted    = (state_q == HALTED);
  assign imem.req  = (state_q == ISSUE) && !stall && !pc_sel && !halted;
  assign imem.addr = pc_q;
  assign if_pc     = pc_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_valid  = id_valid_q;
  assign flush     = pc_sel;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: a memory model answers fetches, a
// reference model of the fetch stream feeds a scoreboard, a monitor checks IF/ID.
module tb_fetch_pc_unit;

  localparam int PC_W     = 9;
  localparam int INS_W    = 32;
  localparam int RESET_PC = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, stall, pc_sel, halt;
  logic [31:0]      br_pc;
  logic [PC_W-1:0]  if_pc, id_pc;
  logic [INS_W-1:0] id_instr;
  logic             id_valid, flush, halted;

  fetch_pc_unit_if #(.PC_W(PC_W), .INS_W(INS_W)) imem ();

  fetch_pc_unit #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .pc_sel   (pc_sel),
    .br_pc    (br_pc),
    .halt     (halt),
    .imem     (imem),
    .if_pc    (if_pc),
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .id_valid (id_valid),
    .flush    (flush),
    .halted   (halted)
  );

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } fetch_t;

  fetch_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: where the next fetch comes from, whether the
  // stage is halted, and the single request the memory is currently serving.
  logic [PC_W-1:0] pc_model;
  bit              halted_model = 0, started = 0, just_reset = 0;
  bit              out_valid = 0, out_poison = 0;
  logic [PC_W-1:0] out_addr;
  int              out_cnt = 0;
  int              halted_cycles = 0, delivered = 0, req_count = 0;

  int   p_stall = 0, p_redir = 0, p_halt = 0, p_spur = 0, max_lat = 1;
  bit   rst_req = 1, force_redir = 0, force_halt = 0;
  logic [31:0] force_target;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [INS_W-1:0] mem_word(logic [PC_W-1:0] a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h9E37_79B1);
  endfunction

  // One clock cycle: check at negedge, commit the model at posedge, drive after.
  task automatic step();
    bit              req_s;
    logic [PC_W-1:0] addr_s;
    fetch_t          e;
    @(negedge clk);
    check("flush", flush, pc_sel);
    req_s  = imem.req;
    addr_s = imem.addr;
    if (started) begin
      check("if_pc", if_pc, pc_model);
      check("imem_addr", addr_s, pc_model);
      check("halted", halted, halted_model);
      if (pc_sel || stall || halted_model) check("req_blocked", req_s, 0);
      if (halted_model) check("halted_id_valid", id_valid, 0);
      if (req_s && !reset) check("single_outstanding", out_valid, 0);
      if (just_reset) begin
        check("reset_id_valid", id_valid, 0);
        check("reset_id_pc", id_pc, 0);
        check("reset_id_instr", id_instr, NOP);
        just_reset = 0;
      end
    end
    if (req_s && !reset) req_count++;

    @(posedge clk);
    if (reset) begin
      pc_model      = PC_W'(RESET_PC);
      halted_model  = 0;
      out_valid     = 0;
      halted_cycles = 0;
      started       = 1;
      just_reset    = 1;
      exp_q.delete();
    end else begin
      if (imem.rvalid && out_valid) begin
        if (!out_poison && !pc_sel && !halted_model) begin
          e.pc    = out_addr;
          e.instr = mem_word(out_addr);
          exp_q.push_back(e);
          pc_model = pc_model + PC_W'(4);
        end
        out_valid = 0;
      end
      if (pc_sel && !halted_model) begin
        exp_q.delete();
        pc_model = br_pc[PC_W-1:0] & ~PC_W'(3);
        if (out_valid) out_poison = 1;
        if (halt) halted_model = 1;
      end
      if (req_s) begin
        out_valid  = 1;
        out_poison = 0;
        out_addr   = addr_s;
        out_cnt    = $urandom_range(max_lat, 1);
      end
      halted_cycles = halted_model ? halted_cycles + 1 : 0;
    end

    #1;
    reset  = rst_req;
    stall  = ($urandom_range(99) < p_stall);
    pc_sel = 1'b0;
    halt   = 1'b0;
    br_pc  = $urandom;
    if (force_redir) begin
      pc_sel      = 1'b1;
      halt        = force_halt;
      br_pc       = force_target;
      force_redir = 0;
    end else if ($urandom_range(99) < p_redir) begin
      pc_sel = 1'b1;
      halt   = ($urandom_range(99) < p_halt);
    end
    imem.rvalid = 1'b0;
    imem.rdata  = $urandom;
    if (out_valid && !rst_req) begin
      if (out_cnt <= 1) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem_word(out_addr);
      end else begin
        out_cnt--;
      end
    end else if (!out_valid && $urandom_range(99) < p_spur) begin
      imem.rvalid = 1'b1;
    end
  endtask

  // Monitor: a new IF/ID entry is any live cycle whose contents differ from
  // the previous live cycle; each one must match the scoreboard head.
  fetch_t mon_prev;
  bit     mon_prev_v = 0;
  initial begin
    fetch_t e;
    forever begin
      @(negedge clk);
      if (started && id_valid === 1'b1 &&
          (!mon_prev_v || id_pc !== mon_prev.pc || id_instr !== mon_prev.instr)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_delivery: got pc 0x%0h instr 0x%0h expected none at %0t",
                   id_pc, id_instr, $time);
        end else begin
          e = exp_q.pop_front();
          check("id_pc", id_pc, e.pc);
          check("id_instr", id_instr, e.instr);
          delivered++;
        end
      end
      mon_prev_v     = (id_valid === 1'b1);
      mon_prev.pc    = id_pc;
      mon_prev.instr = id_instr;
    end
  end

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    pc_sel      = 1'b0;
    halt        = 1'b0;
    br_pc       = '0;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;

    // Reset, then 1-cycle memory with no stalls: one request every 2nd cycle.
    step();
    step();
    rst_req = 0;
    step();
    req_count = 0;
    repeat (20) step();
    check("throughput_reqs", req_count, 10);

    // Randomized traffic: stalls, redirects, halts, spurious strobes, resets.
    p_stall = 30; p_redir = 5; p_halt = 10; p_spur = 10; max_lat = 3;
    for (int i = 0; i < 3000; i++) begin
      rst_req = (halted_cycles >= 20) || ($urandom_range(499) == 0);
      step();
    end

    // Wrap at the top of the address space; upper and low br_pc bits ignored.
    p_stall = 0; p_redir = 0; p_spur = 0; max_lat = 1;
    rst_req = 1;
    step();
    rst_req = 0;
    step();
    force_target = 32'hFFFF_FFFB;
    force_halt   = 0;
    force_redir  = 1;
    repeat (12) step();
    check("wrap_if_pc", if_pc, 9'h00C);

    // Halt: redirect to 0x24, stay idle 20 cycles, then reset restarts fetch.
    force_target = 32'h0000_0024;
    force_halt   = 1;
    force_redir  = 1;
    repeat (22) step();
    rst_req = 1;
    step();
    rst_req = 0;
    repeat (10) step();

    check("liveness", (delivered > 100), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Pipeline fetch stage on the receiving side of branch resolution: owns the PC register and consumes the EX-stage redirect (pc_sel, br_pc, halt).
- Fetches from instruction memory over a single-outstanding request/response handshake and fills the IF/ID register, with a one-entry skid buffer for hazard-unit stalls.
- Squashes stale fetches on redirect and stops fetching permanently on halt.

Parameters:
PC_W, 9, PC/instruction address width in bits
INS_W, 32, instruction width in bits
RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold IF/ID and suppress new issue
pc_sel  in  1  EX redirect: load br_pc (taken branch/jump or halt)
br_pc  in  32  redirect target; bits [PC_W-1:0] used, [1:0] forced to 0
halt  in  1  qualifies pc_sel: redirect and enter HALTED
imem_req  out  1  one-cycle request pulse
imem_addr  out  PC_W  request address, equals pc_q
imem_rdata  in  INS_W  response data
imem_rvalid  in  1  response strobe, >=1 cycle after imem_req
if_pc  out  PC_W  current PC register pc_q
id_pc  out  PC_W  IF/ID PC
id_instr  out  INS_W  IF/ID instruction
id_valid  out  1  IF/ID holds a live instruction
flush  out  1  combinational, equals pc_sel; kills ID/EX this cycle
halted  out  1  block is in HALTED

Behaviour:
- Reset values: pc_q=RESET_PC, state=ISSUE, id_valid=0, id_pc=0, id_instr=NOP (32'h00000013), imem_req=0, halted=0, skid buffer empty. flush follows pc_sel even during reset.
- Reset mid-operation discards everything, including any outstanding response. imem_rvalid outside WAIT/DROP is ignored.
- Priority each cycle: reset > pc_sel (with or without halt) > stall > normal flow.
- imem_req = (state==ISSUE) && !stall && !pc_sel && !halted. imem_addr = pc_q at all times.
- States:
  - ISSUE: request pulsed -> WAIT. If stall, stay with no request. IF/ID is held.
  - WAIT: on imem_rvalid and !stall: id_instr<=rdata, id_pc<=pc_q, id_valid<=1, pc_q<=pc_q+4, then -> ISSUE. On rvalid and stall: buffer {rdata, pc_q}, pc_q<=pc_q+4, -> HOLD. Without rvalid: id_valid<=0 if !stall, else hold.
  - HOLD: no requests. When !stall: IF/ID<=buffer, id_valid<=1, -> ISSUE.
  - DROP: await rvalid, discard the data, -> ISSUE. id_valid<=0.
  - HALTED: no requests, id_valid<=0, halted=1. Exit only by reset.
- Redirect (pc_sel=1), in any non-HALTED state:
  - pc_q<={br_pc[PC_W-1:2],2'b00}, id_valid<=0, skid buffer cleared.
  - Next state: WAIT without rvalid this cycle -> DROP. DROP without rvalid -> stays DROP. WAIT/DROP with rvalid this cycle -> response discarded, -> ISSUE. ISSUE/HOLD -> ISSUE.
  - halt=1 -> HALTED instead. A pending response is still consumed silently; the memory must not be left orphaned.
- Arithmetic: pc_q+4 is modulo 2^PC_W (0x1FC -> 0x000 for PC_W=9). br_pc upper bits are ignored.
- Throughput: one instruction per two cycles at 1-cycle memory latency; no instruction is duplicated or lost across stalls.

Decomposition:
- Shared package pipeline_pkg:
  - fetch_state_t enum {ISSUE, WAIT, HOLD, DROP, HALTED}
  - NOP_INSTR = 32'h00000013
- The skid buffer is natural as sub-module fetch_skid_buf: 1 entry, load/pop/clear, holds {pc, instr}. The FSM and PC stay in the top.

Test Plan:
- Reset, 1-cycle-latency memory, no stalls -> imem_req every 2nd cycle at 0,4,8. id_pc 0,4,8 with id_valid=1. if_pc ends at 0xC.
- stall=1 on the cycle rvalid returns for 0x8, held 3 cycles -> state HOLD, imem_req=0, if_pc=0xC. On release id_pc=0x8 exactly once, then fetch resumes at 0xC.
- Request for 0x10 outstanding (WAIT), 3-cycle latency, pc_sel=1 br_pc=0x40 -> flush=1 that cycle, DROP state. Response for 0x10 never reaches IF/ID; next id_pc=0x40.
- pc_sel=1 br_pc=0x43 with rvalid and stall in the same cycle -> data discarded, pc_q=0x40, next imem_addr=0x40, id_valid=0.
- pc_sel=1 halt=1 br_pc=0x24 -> if_pc=0x24, halted=1, no further imem_req over 20 cycles, id_valid=0. reset -> if_pc=RESET_PC, fetching restarts.
- PC_W=9, sequential fetch from 0x1F8 -> id_pc 0x1F8, 0x1FC, 0x000 (wrap, no X, no stall).
